// File: rtl/load_arb_pkg.sv
// Shared types and defaults for the load-unit read-port arbiter.
// Optional feature macro used by this slice: LOAD_ARB_TIMEOUT_EN.
package load_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

    // Index width, never zero so a 1-bit vector exists even for tiny counts.
    function automatic int load_arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = load_arb_idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/load_bus_arbiter_if.sv
// Load-unit and memory-side signal bundle of the arbiter.
// timeout_err exists only when LOAD_ARB_TIMEOUT_EN is defined.
interface load_bus_arbiter_if #(
    parameter int NUM_REQ = load_arb_pkg::DEF_NUM_REQ,
    parameter int ADDR_W  = load_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W  = load_arb_pkg::DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        data_ready;
    logic [DATA_W-1:0]         rd_data;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_ack;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      arb_busy;
`ifdef LOAD_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    modport master (
        input  req, req_addr, mem_ack, mem_rdata,
        output data_ready, rd_data, mem_req, mem_addr, arb_busy
`ifdef LOAD_ARB_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output req, req_addr, mem_ack, mem_rdata,
        input  data_ready, rd_data, mem_req, mem_addr, arb_busy
`ifdef LOAD_ARB_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface

// File: rtl/load_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] cand_s;

    // Walk candidates from rr_ptr upward, wrapping by compare rather than modulo.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = {IDX_W{1'b0}};
        cand_s    = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_valid && req[cand_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s;
            end else begin
                gnt_valid = gnt_valid;
            end
            if (cand_s == LAST_IDX) begin
                cand_s = {IDX_W{1'b0}};
            end else begin
                cand_s = cand_s + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/load_bus_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ load units.
// Define LOAD_ARB_TIMEOUT_EN to abort reads that see no mem_ack within TIMEOUT_CYCLES.
module load_bus_arbiter
    import load_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_bus_arbiter_if.master bus
);

    localparam int               IDX_W    = load_arb_idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("load_bus_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
        end
    endgenerate

    arb_state_t         state_r,      state_s;
    logic [IDX_W-1:0]   grant_r,      grant_s;
    logic [IDX_W-1:0]   rr_ptr_r,     rr_ptr_s;
    logic [ADDR_W-1:0]  mem_addr_r,   mem_addr_s;
    logic               mem_req_r,    mem_req_s;
    logic [NUM_REQ-1:0] data_ready_r, data_ready_s;
    logic [DATA_W-1:0]  rd_data_r,    rd_data_s;
    logic               arb_busy_r,   arb_busy_s;
    logic               gnt_valid_s;
    logic [IDX_W-1:0]   gnt_idx_s;

`ifdef LOAD_ARB_TIMEOUT_EN
    localparam int              CNT_W    = load_arb_idx_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             timeout_err_r, timeout_err_s;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (bus.req),
        .rr_ptr    (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Next-state and next-output logic of the grant/read/respond sequence.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        rr_ptr_s     = rr_ptr_r;
        mem_addr_s   = mem_addr_r;
        mem_req_s    = mem_req_r;
        data_ready_s = {NUM_REQ{1'b0}};
        rd_data_s    = rd_data_r;
        arb_busy_s   = arb_busy_r;
`ifdef LOAD_ARB_TIMEOUT_EN
        cnt_s         = cnt_r;
        timeout_err_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    grant_s    = gnt_idx_s;
                    mem_addr_s = bus.req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
                    mem_req_s  = 1'b1;
                    arb_busy_s = 1'b1;
                    state_s    = BUSY;
`ifdef LOAD_ARB_TIMEOUT_EN
                    cnt_s      = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // An ack in the last counted cycle takes priority over the timeout.
                if (bus.mem_ack) begin
                    rd_data_s             = bus.mem_rdata;
                    mem_req_s             = 1'b0;
                    data_ready_s[grant_r] = 1'b1;
                    state_s               = RESP;
`ifdef LOAD_ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_LAST) begin
                    rd_data_s             = {DATA_W{1'b0}};
                    mem_req_s             = 1'b0;
                    data_ready_s[grant_r] = 1'b1;
                    timeout_err_s         = 1'b1;
                    state_s               = RESP;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = BUSY;
                end
`endif
            end
            RESP: begin
                if (grant_r == LAST_IDX) begin
                    rr_ptr_s = {IDX_W{1'b0}};
                end else begin
                    rr_ptr_s = grant_r + IDX_W'(1);
                end
                arb_busy_s = 1'b0;
                state_s    = IDLE;
            end
            default: begin
                mem_req_s  = 1'b0;
                arb_busy_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= {IDX_W{1'b0}};
            rr_ptr_r     <= {IDX_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_req_r    <= 1'b0;
            data_ready_r <= {NUM_REQ{1'b0}};
            rd_data_r    <= {DATA_W{1'b0}};
            arb_busy_r   <= 1'b0;
`ifdef LOAD_ARB_TIMEOUT_EN
            cnt_r         <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            rr_ptr_r     <= rr_ptr_s;
            mem_addr_r   <= mem_addr_s;
            mem_req_r    <= mem_req_s;
            data_ready_r <= data_ready_s;
            rd_data_r    <= rd_data_s;
            arb_busy_r   <= arb_busy_s;
`ifdef LOAD_ARB_TIMEOUT_EN
            cnt_r         <= cnt_s;
            timeout_err_r <= timeout_err_s;
`endif
        end
    end

    assign bus.data_ready = data_ready_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.arb_busy   = arb_busy_r;
`ifdef LOAD_ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_r;
`endif

endmodule

// File: tb/tb_load_bus_arbiter.sv
// Self-checking bench for load_bus_arbiter: transaction-level model plus directed scenarios.
// Build with LOAD_ARB_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_load_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef LOAD_ARB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    load_bus_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              m_out, m_resp, m_tout;
    int              m_unit, m_start, m_wait;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_rdata;

    function automatic int pick(input logic [N-1:0] r, input int start);
        int p;
        p = -1;
        for (int k = 0; k < N; k++)
            if (p < 0 && r[(start + k) % N]) p = (start + k) % N;
        return p;
    endfunction

    function automatic logic [N-1:0] exp_ready(input bit resp, input int u);
        logic [N-1:0] v;
        v = '0;
        if (resp) v[u] = 1'b1;
        return v;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int p;
        p = -1;
        for (int k = 0; k < N; k++)
            if (p < 0 && v[k]) p = k;
        return p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= 1'b0; m_resp <= 1'b0; m_tout <= 1'b0;
            m_unit <= 0; m_start <= 0; m_wait <= 0;
            m_addr <= '0; m_rdata <= '0;
        end else if (m_resp) begin
            m_resp  <= 1'b0;
            m_tout  <= 1'b0;
            m_start <= (m_unit + 1) % N;
        end else if (m_out) begin
            m_wait <= m_wait + 1;
            if (bus.mem_ack) begin
                m_rdata <= bus.mem_rdata; m_out <= 1'b0; m_resp <= 1'b1;
            end else if (TO_EN && m_wait + 1 == TO) begin
                m_rdata <= '0; m_out <= 1'b0; m_resp <= 1'b1; m_tout <= 1'b1;
            end
        end else if (bus.req != '0) begin
            m_unit <= pick(bus.req, m_start);
            m_addr <= bus.req_addr[pick(bus.req, m_start)*AW +: AW];
            m_out  <= 1'b1;
            m_wait <= 0;
        end
    end

    // ---------------- per-cycle comparison and completion log ----------------
    int            gq[$];
    int            gt[$];
    logic [DW-1:0] gd[$];

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("mem_req",    bus.mem_req,    m_out);
            check("mem_addr",   bus.mem_addr,   m_addr);
            check("data_ready", bus.data_ready, exp_ready(m_resp, m_unit));
            check("rd_data",    bus.rd_data,    m_rdata);
            check("arb_busy",   bus.arb_busy,   m_out | m_resp);
`ifdef LOAD_ARB_TIMEOUT_EN
            check("timeout_err", bus.timeout_err, m_tout);
`endif
            if (bus.data_ready != '0) begin
                gq.push_back(oh_idx(bus.data_ready));
                gt.push_back(cyc);
                gd.push_back(bus.rd_data);
            end
        end
    end

    // ---------------- stimulus: load units and memory responder ----------------
    bit            ack_en    = 1'b0;
    int            ack_delay = 0;
    int            ack_cnt   = 0;
    logic [DW-1:0] rdata_xor = '0;
    logic [N-1:0]  keep_mask = '0;
    logic [N-1:0]  rearm_mask = '0;
    logic [N-1:0]  rearm_pend = '0;
    bit            late_ack  = 1'b0;

    task automatic cycle();
        @(negedge clk);
        bus.req    = bus.req | rearm_pend;
        rearm_pend = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.data_ready[i] && !keep_mask[i]) begin
                bus.req[i] = 1'b0;
                if (rearm_mask[i]) rearm_pend[i] = 1'b1;
            end
        end
        if (ack_en && bus.mem_req) begin
            if (ack_cnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata_xor ^ bus.mem_addr;
                ack_cnt       = 0;
            end else begin
                bus.mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            ack_cnt     = 0;
        end
        if (late_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hBAD0_0BAD;
            late_ack      = 1'b0;
        end
    endtask

    task automatic wait_ready(input string nm, output logic [N-1:0] dr,
                              output int lat, output int req_cycles);
        bit found;
        found = 1'b0; lat = 0; req_cycles = 0; dr = '0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle();
            lat++;
            if (bus.mem_req) req_cycles++;
            if (bus.data_ready != '0) begin
                found = 1'b1;
                dr    = bus.data_ready;
            end
        end
        check({nm, " ready seen"}, found, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] dr;
        int lat, rc, t0;

        bus.req = '0; bus.req_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst mem_req",    bus.mem_req,    1'b0);
        check("rst data_ready", bus.data_ready, 4'b0000);
        check("rst rd_data",    bus.rd_data,    32'h0);
        check("rst mem_addr",   bus.mem_addr,   32'h0);
        check("rst arb_busy",   bus.arb_busy,   1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cycle();

        // Single unit 2, ack one cycle after mem_req.
        ack_en = 1'b1; ack_delay = 1; rdata_xor = 32'hCAFE_0101;
        bus.req_addr[2*AW +: AW] = 32'h0000_0100;
        bus.req[2] = 1'b1;
        wait_ready("t2", dr, lat, rc);
        check("t2 data_ready", dr,           4'b0100);
        check("t2 rd_data",    bus.rd_data,  32'hCAFE_0001);
        check("t2 mem_addr",   bus.mem_addr, 32'h0000_0100);
        check("t2 latency",    lat,          3);
        repeat (3) cycle();

        // Reset in the middle of a read.
        ack_en = 1'b0;
        bus.req[1] = 1'b1;
        repeat (3) cycle();
        check("t1 busy before reset", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t1 mem_req",    bus.mem_req,    1'b0);
        check("t1 arb_busy",   bus.arb_busy,   1'b0);
        check("t1 data_ready", bus.data_ready, 4'b0000);
        check("t1 rd_data",    bus.rd_data,    32'h0);
        check("t1 mem_addr",   bus.mem_addr,   32'h0);
        bus.req = '0;
        gq.delete(); gt.delete(); gd.delete();
        cycle();
        #2 rst_n = 1'b1;
        repeat (5) cycle();
        check("t1 no ready after release", gq.size(), 0);

        // All four requesting, immediate ack.
        ack_en = 1'b1; ack_delay = 0; rdata_xor = 32'h5A5A_0000;
        bus.req_addr = {32'h0000_1030, 32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
        gq.delete(); gt.delete(); gd.delete();
        t0 = cyc;
        bus.req = 4'b1111;
        for (int k = 0; k < 40 && gq.size() < 4; k++) cycle();
        check("t3 count", gq.size(), 4);
        if (gq.size() == 4) begin
            check("t3 first latency", gt[0] - t0, 2);
            for (int k = 0; k < 4; k++) begin
                check("t3 order", gq[k], k);
                check("t3 rdata", gd[k], 32'h5A5A_1000 ^ (k * 16));
                if (k > 0) check("t3 spacing", gt[k] - gt[k-1], 3);
            end
        end
        repeat (2) cycle();

        // Fairness: unit 0 re-requests after each service, unit 3 holds req.
        gq.delete(); gt.delete(); gd.delete();
        keep_mask = 4'b1000; rearm_mask = 4'b0001;
        bus.req = 4'b1001;
        for (int k = 0; k < 60 && gq.size() < 4; k++) cycle();
        bus.req = '0; rearm_pend = '0; keep_mask = '0; rearm_mask = '0;
        check("t4 count", gq.size(), 4);
        if (gq.size() == 4) begin
            check("t4 grant0", gq[0], 0);
            check("t4 grant1", gq[1], 3);
            check("t4 grant2", gq[2], 0);
            check("t4 grant3", gq[3], 3);
        end
        repeat (3) cycle();

        // Granted unit drops req and changes its address during the read.
        ack_delay = 5; rdata_xor = 32'h1111_0000;
        bus.req_addr[1*AW +: AW] = 32'h2000_0010;
        bus.req[1] = 1'b1;
        repeat (2) cycle();
        check("t5 mem_addr latched", bus.mem_addr, 32'h2000_0010);
        bus.req[1] = 1'b0;
        bus.req_addr[1*AW +: AW] = 32'hDEAD_BEEF;
        wait_ready("t5", dr, lat, rc);
        check("t5 data_ready", dr,           4'b0010);
        check("t5 mem_addr",   bus.mem_addr, 32'h2000_0010);
        check("t5 rd_data",    bus.rd_data,  32'h3111_0010);
        repeat (2) cycle();

`ifdef LOAD_ARB_TIMEOUT_EN
        // No ack: abort after TO busy cycles, then a stray ack in IDLE.
        ack_en = 1'b0;
        bus.req_addr[2*AW +: AW] = 32'h0000_0300;
        bus.req[2] = 1'b1;
        wait_ready("t6", dr, lat, rc);
        check("t6 data_ready",   dr,              4'b0100);
        check("t6 timeout_err",  bus.timeout_err, 1'b1);
        check("t6 rd_data",      bus.rd_data,     32'h0);
        check("t6 busy cycles",  rc,              8);
        gq.delete();
        late_ack = 1'b1;
        repeat (5) cycle();
        check("t6 late ack ignored", gq.size(), 0);
        check("t6 err cleared", bus.timeout_err, 1'b0);
`else
        // No ack: the read stays pending until memory answers.
        ack_en = 1'b0;
        bus.req_addr[2*AW +: AW] = 32'h0000_0300;
        bus.req[2] = 1'b1;
        repeat (20) cycle();
        check("t6 still waiting",  bus.mem_req,    1'b1);
        check("t6 still busy",     bus.arb_busy,   1'b1);
        check("t6 no ready",       bus.data_ready, 4'b0000);
        ack_en = 1'b1; ack_delay = 0; rdata_xor = 32'h0;
        wait_ready("t6", dr, lat, rc);
        check("t6 data_ready", dr,          4'b0100);
        check("t6 rd_data",    bus.rd_data, 32'h0000_0300);
`endif
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
